// File: rtl/mos6502_pkg.sv
// ============================================================================
// mos6502_pkg
// Shared definitions for the status-byte controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mos6502_pkg;

   localparam int FLAG_N = 7;
   localparam int FLAG_V = 6;
   localparam int FLAG_U = 5;
   localparam int FLAG_B = 4;
   localparam int FLAG_D = 3;
   localparam int FLAG_I = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   localparam logic [2:0] FOP_NONE = 3'd0;
   localparam logic [2:0] FOP_CLC  = 3'd1;
   localparam logic [2:0] FOP_SEC  = 3'd2;
   localparam logic [2:0] FOP_CLI  = 3'd3;
   localparam logic [2:0] FOP_SEI  = 3'd4;
   localparam logic [2:0] FOP_CLV  = 3'd5;
   localparam logic [2:0] FOP_CLD  = 3'd6;
   localparam logic [2:0] FOP_SED  = 3'd7;

   localparam logic [1:0] VEC_NONE = 2'b00;
   localparam logic [1:0] VEC_IRQ  = 2'b01;
   localparam logic [1:0] VEC_NMI  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PUSH  = 2'd1,
      ST_SET_I = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_IRQ  = 2'd1,
      SRC_BRK  = 2'd2,
      SRC_NMI  = 2'd3
   } int_src_t;

   // Bit 5 reads as 1 and B never lives in the register; D is dropped without decimal support.
   function automatic logic [7:0] sanitize_p(input logic [7:0] p, input logic d_en);
      logic [7:0] s;
      s         = p;
      s[FLAG_U] = 1'b1;
      s[FLAG_B] = 1'b0;
      if (!d_en) s[FLAG_D] = 1'b0;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nmi_edge_detect.sv
// ============================================================================
// nmi_edge_detect
// Falling-edge detector and pending latch for NMI; a new edge beats a clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nmi_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_nmi_n,
   input  logic i_clr,
   output logic o_pend
);

   logic r_prev;
   logic r_pend;
   logic w_fall;

   assign w_fall = r_prev & ~i_nmi_n;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= 1'b1;
         r_pend <= 1'b0;
      end else begin
         r_prev <= i_nmi_n;
         if (w_fall)
            r_pend <= 1'b1;
         else if (i_clr)
            r_pend <= 1'b0;
      end
   end

   assign o_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/status_flag_ctrl.sv
// ============================================================================
// status_flag_ctrl
// Owns the 6502 P register and sequences interrupt entry (push P, set I, vector).
// Build option: DECIMAL_FLAG_EN implements the D flag; otherwise D is fixed at 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module status_flag_ctrl
   import mos6502_pkg::*;
#(
   parameter logic [7:0] P_RESET_VALUE = 8'h24,
   parameter bit         IRQ_MASKABLE  = 1'b1
) (
   input  logic       FSM_Signal,
   input  logic       reset,
   input  logic       alu_upd,
   input  logic [3:0] alu_mask,
   input  logic [3:0] alu_flags,
   input  logic [2:0] flag_op,
   input  logic       plp_load,
   input  logic [7:0] plp_data,
   input  logic       irq_n,
   input  logic       nmi_n,
   input  logic       brk_req,
   input  logic       insn_boundary,
   input  logic       push_ready,
   output logic       push_valid,
   output logic [7:0] push_data,
   output logic [1:0] int_vector_sel,
   output logic       int_busy,
   output logic       int_done,
   output logic [7:0] p_out
);

`ifdef DECIMAL_FLAG_EN
   localparam logic C_D_EN = 1'b1;
`else
   localparam logic C_D_EN = 1'b0;
`endif

   localparam logic [7:0] C_P_INIT = sanitize_p(P_RESET_VALUE, C_D_EN);

   state_t     r_state;
   int_src_t   r_src;
   logic [7:0] r_p;
   logic       r_push_valid;
   logic [7:0] r_push_data;
   logic [1:0] r_vec;
   logic       r_busy;
   logic       r_done;

   logic       w_nmi_pend;
   logic       w_nmi_clr;
   logic       w_irq_act;
   logic [7:0] w_p_wr;
   logic [7:0] w_push_byte;
   int_src_t   w_src_sel;
   int_src_t   w_src_push;

   nmi_edge_detect u_nmi (
      .clk     (FSM_Signal),
      .rst     (reset),
      .i_nmi_n (nmi_n),
      .i_clr   (w_nmi_clr),
      .o_pend  (w_nmi_pend)
   );

   assign w_irq_act = ~irq_n & (~r_p[FLAG_I] | ~IRQ_MASKABLE);
   assign w_nmi_clr = (r_state == ST_SET_I) && (r_src == SRC_NMI);

   // Flag-instruction bit is applied after the ALU bits so it wins on C/V collisions.
   always_comb begin
      w_p_wr = r_p;
      if (plp_load) begin
         w_p_wr = sanitize_p(plp_data, C_D_EN);
      end else begin
         if (alu_upd) begin
            if (alu_mask[3]) w_p_wr[FLAG_N] = alu_flags[3];
            if (alu_mask[2]) w_p_wr[FLAG_V] = alu_flags[2];
            if (alu_mask[1]) w_p_wr[FLAG_Z] = alu_flags[1];
            if (alu_mask[0]) w_p_wr[FLAG_C] = alu_flags[0];
         end
         case (flag_op)
            FOP_NONE: ;
            FOP_CLC:  w_p_wr[FLAG_C] = 1'b0;
            FOP_SEC:  w_p_wr[FLAG_C] = 1'b1;
            FOP_CLI:  w_p_wr[FLAG_I] = 1'b0;
            FOP_SEI:  w_p_wr[FLAG_I] = 1'b1;
            FOP_CLV:  w_p_wr[FLAG_V] = 1'b0;
            FOP_CLD:  if (C_D_EN) w_p_wr[FLAG_D] = 1'b0;
            FOP_SED:  if (C_D_EN) w_p_wr[FLAG_D] = 1'b1;
            default:  ;
         endcase
      end
   end

   always_comb begin
      w_src_sel = SRC_NONE;
      if (w_nmi_pend)
         w_src_sel = SRC_NMI;
      else if (brk_req)
         w_src_sel = SRC_BRK;
      else if (w_irq_act)
         w_src_sel = SRC_IRQ;
   end

   // A pending NMI takes over a BRK/IRQ entry still waiting on the stack path.
   assign w_src_push = w_nmi_pend ? SRC_NMI : r_src;

   always_comb begin
      w_push_byte         = w_p_wr;
      w_push_byte[FLAG_B] = (w_src_sel == SRC_BRK);
   end

   always_ff @(negedge FSM_Signal or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_src        <= SRC_NONE;
         r_p          <= C_P_INIT;
         r_push_valid <= 1'b0;
         r_push_data  <= 8'h00;
         r_vec        <= VEC_NONE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_p <= w_p_wr;
               if (insn_boundary && (w_src_sel != SRC_NONE)) begin
                  r_src        <= w_src_sel;
                  r_push_valid <= 1'b1;
                  r_push_data  <= w_push_byte;
                  r_busy       <= 1'b1;
                  r_state      <= ST_PUSH;
               end
            end
            ST_PUSH: begin
               r_src <= w_src_push;
               if (push_ready) begin
                  r_push_valid <= 1'b0;
                  r_push_data  <= 8'h00;
                  r_vec        <= (w_src_push == SRC_NMI) ? VEC_NMI : VEC_IRQ;
                  r_state      <= ST_SET_I;
               end
            end
            ST_SET_I: begin
               r_p[FLAG_I] <= 1'b1;
               r_done      <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_vec   <= VEC_NONE;
               r_busy  <= 1'b0;
               r_src   <= SRC_NONE;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign push_valid     = r_push_valid;
   assign push_data      = r_push_data;
   assign int_vector_sel = r_vec;
   assign int_busy       = r_busy;
   assign int_done       = r_done;
   assign p_out          = r_p;

endmodule

`default_nettype wire

// File: tb/tb_status_flag_ctrl.sv
// ============================================================================
// tb_status_flag_ctrl
// Directed and random stimulus against a cycle-level reference of the P/interrupt rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_status_flag_ctrl;

`ifdef DECIMAL_FLAG_EN
   localparam bit D_EN = 1'b1;
`else
   localparam bit D_EN = 1'b0;
`endif

   logic       FSM_Signal;
   logic       reset;
   logic       alu_upd;
   logic [3:0] alu_mask;
   logic [3:0] alu_flags;
   logic [2:0] flag_op;
   logic       plp_load;
   logic [7:0] plp_data;
   logic       irq_n;
   logic       nmi_n;
   logic       brk_req;
   logic       insn_boundary;
   logic       push_ready;
   logic       push_valid;
   logic [7:0] push_data;
   logic [1:0] int_vector_sel;
   logic       int_busy;
   logic       int_done;
   logic [7:0] p_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: P, NMI edge tracking, and progress of an interrupt entry.
   logic [7:0] m_p;
   logic [7:0] m_pdata;
   bit         m_prev, m_pend, m_active, m_pushed;
   int         m_post;
   int         m_src;    // 0 none, 1 IRQ, 2 BRK, 3 NMI

   status_flag_ctrl #(.P_RESET_VALUE(8'h24), .IRQ_MASKABLE(1'b1)) dut (
      .FSM_Signal     (FSM_Signal),
      .reset          (reset),
      .alu_upd        (alu_upd),
      .alu_mask       (alu_mask),
      .alu_flags      (alu_flags),
      .flag_op        (flag_op),
      .plp_load       (plp_load),
      .plp_data       (plp_data),
      .irq_n          (irq_n),
      .nmi_n          (nmi_n),
      .brk_req        (brk_req),
      .insn_boundary  (insn_boundary),
      .push_ready     (push_ready),
      .push_valid     (push_valid),
      .push_data      (push_data),
      .int_vector_sel (int_vector_sel),
      .int_busy       (int_busy),
      .int_done       (int_done),
      .p_out          (p_out)
   );

   initial begin
      FSM_Signal = 1'b1;
      forever #5 FSM_Signal = ~FSM_Signal;
   end

   function automatic logic [7:0] fix_p(input logic [7:0] v);
      logic [7:0] f;
      f    = v;
      f[5] = 1'b1;
      f[4] = 1'b0;
      if (!D_EN) f[3] = 1'b0;
      return f;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_p      = fix_p(8'h24);
      m_pdata  = 8'h00;
      m_prev   = 1'b1;
      m_pend   = 1'b0;
      m_active = 1'b0;
      m_pushed = 1'b0;
      m_post   = 0;
      m_src    = 0;
   endtask

   task automatic model_update();
      logic       nedge, clr, irq;
      logic [7:0] np;
      int         nsrc;
      nedge = m_prev && !nmi_n;
      clr   = 1'b0;
      if (!m_active) begin
         np = m_p;
         if (plp_load) begin
            np = fix_p(plp_data);
         end else begin
            if (alu_upd) begin
               if (alu_mask[3]) np[7] = alu_flags[3];
               if (alu_mask[2]) np[6] = alu_flags[2];
               if (alu_mask[1]) np[1] = alu_flags[1];
               if (alu_mask[0]) np[0] = alu_flags[0];
            end
            case (flag_op)
               3'd1: np[0] = 1'b0;
               3'd2: np[0] = 1'b1;
               3'd3: np[2] = 1'b0;
               3'd4: np[2] = 1'b1;
               3'd5: np[6] = 1'b0;
               3'd6: if (D_EN) np[3] = 1'b0;
               3'd7: if (D_EN) np[3] = 1'b1;
               default: ;
            endcase
         end
         irq  = !irq_n && !m_p[2];
         nsrc = m_pend ? 3 : (brk_req ? 2 : (irq ? 1 : 0));
         if (insn_boundary && nsrc != 0) begin
            m_active   = 1'b1;
            m_pushed   = 1'b0;
            m_post     = 0;
            m_src      = nsrc;
            m_pdata    = np;
            m_pdata[4] = (nsrc == 2);
         end
         m_p = np;
      end else if (!m_pushed) begin
         if (m_pend) m_src = 3;
         if (push_ready) begin
            m_pushed = 1'b1;
            m_post   = 1;
         end
      end else if (m_post == 1) begin
         m_p[2] = 1'b1;
         clr    = (m_src == 3);
         m_post = 2;
      end else begin
         m_active = 1'b0;
         m_pushed = 1'b0;
         m_post   = 0;
         m_src    = 0;
      end
      m_pend = nedge ? 1'b1 : (clr ? 1'b0 : m_pend);
      m_prev = nmi_n;
   endtask

   task automatic check_all(input string tag);
      logic pv;
      pv = m_active && !m_pushed;
      chk({tag, ".p_out"}, p_out, m_p);
      chk({tag, ".push_valid"}, {7'd0, push_valid}, {7'd0, pv});
      chk({tag, ".push_data"}, push_data, pv ? m_pdata : 8'h00);
      chk({tag, ".vec"}, {6'd0, int_vector_sel},
          (m_active && m_pushed) ? ((m_src == 3) ? 8'd2 : 8'd1) : 8'd0);
      chk({tag, ".busy"}, {7'd0, int_busy}, {7'd0, m_active});
      chk({tag, ".done"}, {7'd0, int_done}, {7'd0, (m_active && m_post == 2)});
   endtask

   task automatic step(input string tag);
      @(negedge FSM_Signal);
      model_update();
      #2;
      check_all(tag);
   endtask

   task automatic finish_entry(input string tag, input logic [1:0] vec_exp);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         step(tag);
         if (int_done === 1'b1) begin
            seen = 1'b1;
            chk({tag, ".vec_at_done"}, {6'd0, int_vector_sel}, {6'd0, vec_exp});
            chk({tag, ".i_at_done"}, {7'd0, p_out[2]}, 8'd1);
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s.timeout: observed no int_done expected a pulse", tag);
      end
   endtask

   initial begin
      logic [7:0] pexp;
      alu_upd = 0; alu_mask = 0; alu_flags = 0; flag_op = 0;
      plp_load = 0; plp_data = 0; irq_n = 1; nmi_n = 1;
      brk_req = 0; insn_boundary = 0; push_ready = 0;
      reset = 1'b1;
      #7;
      model_reset();
      check_all("reset");
      chk("reset.p_const", p_out, 8'h24);
      #1 reset = 1'b0;

      // ALU write colliding with SEC on C
      alu_upd = 1; alu_mask = 4'b1111; alu_flags = 4'b1001; flag_op = 3'd2;
      step("alu_sec");
      chk("alu_sec.const", p_out, 8'hA5);
      alu_upd = 0; alu_mask = 0; alu_flags = 0; flag_op = 0;

      plp_load = 1; plp_data = 8'hFF;
      step("plp_ff");
      chk("plp_ff.const", p_out, D_EN ? 8'hEF : 8'hE7);
      plp_data = 8'h00;
      step("plp_00");
      plp_load = 0;

      // BRK with a stalled stack path
      brk_req = 1; insn_boundary = 1; push_ready = 0;
      pexp = m_p | 8'h30;
      step("brk_entry");
      insn_boundary = 0;
      for (int k = 0; k < 3; k++) begin
         step("brk_stall");
         chk("brk_stall.hold", push_data, pexp);
      end
      push_ready = 1;
      finish_entry("brk", 2'b01);
      brk_req = 0; push_ready = 0;
      step("brk_exit");

      // IRQ masked by I, then unmasked by CLI
      irq_n = 0; insn_boundary = 1;
      for (int k = 0; k < 3; k++) step("irq_masked");
      chk("irq_masked.busy", {7'd0, int_busy}, 8'd0);
      insn_boundary = 0; flag_op = 3'd3;
      step("cli");
      flag_op = 0; insn_boundary = 1; push_ready = 1;
      step("irq_entry");
      chk("irq_entry.bflag", {7'd0, push_data[4]}, 8'd0);
      chk("irq_entry.valid", {7'd0, push_valid}, 8'd1);
      insn_boundary = 0; irq_n = 1;
      finish_entry("irq", 2'b01);
      step("irq_exit");

      // NMI hijack of an IRQ push, then a re-arming edge during SET_I
      flag_op = 3'd3;
      step("cli2");
      flag_op = 0; irq_n = 0; insn_boundary = 1; push_ready = 0;
      step("hij_entry");
      insn_boundary = 0; irq_n = 1; nmi_n = 0;
      step("hij_edge");
      nmi_n = 1;
      step("hij_wait");
      push_ready = 1;
      step("hij_seti");
      chk("hij_seti.vec", {6'd0, int_vector_sel}, 8'd2);
      nmi_n = 0;
      step("hij_rearm");
      chk("hij_rearm.done", {7'd0, int_done}, 8'd1);
      nmi_n = 1;
      step("hij_exit");
      insn_boundary = 1;
      step("nmi2_entry");
      chk("nmi2_entry.valid", {7'd0, push_valid}, 8'd1);
      insn_boundary = 0;
      finish_entry("nmi2", 2'b10);
      insn_boundary = 1;
      step("nmi2_exit");
      step("no_third");
      chk("no_third.busy", {7'd0, int_busy}, 8'd0);
      insn_boundary = 0;

      // Reset while pushing
      brk_req = 1; insn_boundary = 1; push_ready = 0;
      step("rstp_entry");
      insn_boundary = 0;
      step("rstp_push");
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all("rst_in_push");
      chk("rst_in_push.p", p_out, 8'h24);
      #2 reset = 1'b0;
      brk_req = 0;

      for (int k = 0; k < 400; k++) begin
         alu_upd       = 1'($urandom_range(0, 1));
         alu_mask      = 4'($urandom);
         alu_flags     = 4'($urandom);
         flag_op       = 3'($urandom);
         plp_load      = ($urandom_range(0, 7) == 0);
         plp_data      = 8'($urandom);
         irq_n         = ($urandom_range(0, 3) != 0);
         nmi_n         = ($urandom_range(0, 5) != 0);
         brk_req       = ($urandom_range(0, 5) == 0);
         insn_boundary = ($urandom_range(0, 2) == 0);
         push_ready    = 1'($urandom_range(0, 1));
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
